memory_ext_pipe: RTL and testbench
==================================

# memory_ext_pipe

Parametrised successor to the external data memory model. It provides a single-port data memory with width and depth set by parameters and a programmable read latency (RD_LAT). It adds an explicit read-valid strobe, a post-reset memory clear sequencer with a busy flag, and optional forwarding of writes into in-flight reads. It sits on the DM bus between the program sequencer chip-select/RW strobes (ps_dm_cslt, ps_dm_wrb), the DAG address (dg_dm_add) and the bus-connect data path (bc_dt / dm_bc_dt).

## Interface
- DMA_SIZE, 3: address width; depth = 2**DMA_SIZE words.
- DMD_SIZE, 16: data word width.
- RD_LAT, 2: read latency in clock edges; legal range 1..8.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- ps_dm_cslt  input  1  chip select; request present this cycle.
- ps_dm_wrb  input  1  1 = write, 0 = read; qualified by ps_dm_cslt.
- dg_dm_add  input  DMA_SIZE  word address.
- bc_dt  input  DMD_SIZE  write data.
- dm_bc_dt  output  DMD_SIZE  read data; all zeros when dm_rd_vld = 0 (no tri-state).
- dm_rd_vld  output  1  read data valid; one-cycle pulse per accepted read.
- dm_busy  output  1  clear sequence running; requests ignored.

## Operation
- Two-state FSM:
  - CLEAR is entered on reset. A DMA_SIZE+1-bit counter writes zero to address 0, 1, …, 2**DMA_SIZE-1, one address per clock. After the last address is written, the FSM moves to RUN.
  - RUN is the normal state. The FSM leaves RUN only on reset.
- dm_busy = 1 exactly while in CLEAR.
- Write accept: ps_dm_cslt & ps_dm_wrb & ~dm_busy at a rising edge. mem[dg_dm_add] <= bc_dt on that edge.
- Read accept: ps_dm_cslt & ~ps_dm_wrb & ~dm_busy at a rising edge.
  - The address is captured and the array is read into pipeline stage 1.
  - Data and a valid bit shift through RD_LAT stages. The last stage drives dm_bc_dt and dm_rd_vld.
- Requests arriving while dm_busy = 1 are dropped silently: no write, no dm_rd_vld. There is no retry.
- Back-to-back reads every cycle are fully pipelined. Throughput is one read per cycle, and results return in issue order.
- A write followed by a read of the same address one or more cycles later returns the new data, because the array is already updated.
- Reset mid-operation (asynchronous):
  - all pipeline valid bits clear, dm_rd_vld = 0, dm_bc_dt = 0;
  - the FSM returns to CLEAR and the clear counter restarts from 0;
  - array contents become zero only as the clear sequence proceeds.

## Timing
- Reset values: dm_bc_dt = 0, dm_rd_vld = 0, dm_busy = 1, clear counter = 0, FSM = CLEAR.
- Clear sequence:
  - the first rising edge after reset deasserts zeroes address 0;
  - the 2**DMA_SIZE-th edge zeroes the last address and enters RUN;
  - dm_busy is low from that edge onward, so the first request can be accepted at edge 2**DMA_SIZE+1.
- Read latency: a read accepted at edge N gives dm_rd_vld = 1 with valid dm_bc_dt for the cycle after edge N+RD_LAT-1. That is, the data is visible after RD_LAT edges, including the accepting edge.
- Write latency: the array is updated at the accepting edge; there are no outputs.
- A read and a write cannot be issued in the same cycle, because ps_dm_wrb selects one.
- Address wrap: dg_dm_add is exactly DMA_SIZE bits, so there is no out-of-range case.

## Configuration
- Macro DM_WR_FWD_EN.
- Defined:
  - a write accepted while reads of the same address are still in pipeline stages 1..RD_LAT-1 overwrites those stages' data with bc_dt;
  - the returned data therefore equals the value stored in the array at the time dm_rd_vld is asserted;
  - valid bits and ordering are unchanged.
- Undefined: a read returns the array contents sampled at its accepting edge, even if a later write to that address happens before the data is returned.
- With RD_LAT = 1 both builds behave identically.

## Test plan
All scenarios use DMA_SIZE = 3, DMD_SIZE = 16, RD_LAT = 2 unless noted.
- Reset/clear:
  - assert reset, release it, and issue write 0x1234 to address 5 on the first edge;
  - required: dm_busy high for exactly 8 edges, the write dropped, and a later read of address 5 returns 0x0000 with a single dm_rd_vld pulse.
- Write then read:
  - write 0xBEEF to address 3, then read address 3 on the next cycle;
  - required: dm_rd_vld = 1 and dm_bc_dt = 0xBEEF two edges after the read is accepted; dm_bc_dt = 0 in every other cycle.
- Streaming:
  - write values 0x0010..0x0017 to addresses 0..7, then issue 8 consecutive reads of addresses 7..0;
  - required: 8 contiguous dm_rd_vld cycles returning 0x0017..0x0010 in order.
- Forwarding (RD_LAT = 3):
  - address 2 holds 0xAAAA; read address 2, then write 0x5555 to address 2 on the next cycle;
  - required: returns 0x5555 with DM_WR_FWD_EN defined, and 0xAAAA without it.
- Reset mid-read:
  - assert reset one cycle after a read is accepted;
  - required: no dm_rd_vld pulse appears, and dm_busy rises asynchronously and then follows the full 8-cycle clear sequence.
- Busy drop:
  - issue reads during the last clear cycle;
  - required: no dm_rd_vld for those reads; the first read issued after dm_busy falls is returned normally.

Source files
------------

// File: rtl/memory_ext_pipe.sv
// memory_ext_pipe: single-port data memory on the DM bus with a programmable
// read latency, an explicit read-valid strobe and a post-reset clear sequencer.
//
// Optional build macro DM_WR_FWD_EN: when defined, a write that hits the
// address of a read still in flight replaces that read's data, so the value
// returned always matches the array contents when dm_rd_vld rises.
//
// Request semantics (single place): a request is present when ps_dm_cslt = 1
// at a rising edge; ps_dm_wrb selects write (1) or read (0). There is no
// ready/stall: while dm_busy = 1 every request is dropped silently, otherwise
// it is accepted on that edge. Each accepted read produces exactly one
// dm_rd_vld pulse RD_LAT edges later (counting the accepting edge), in order.
// RD_LAT must lie in 1..8.
module memory_ext_pipe #(
  parameter int DMA_SIZE = 3,
  parameter int DMD_SIZE = 16,
  parameter int RD_LAT   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ps_dm_cslt,
  input  logic                ps_dm_wrb,
  input  logic [DMA_SIZE-1:0] dg_dm_add,
  input  logic [DMD_SIZE-1:0] bc_dt,
  output logic [DMD_SIZE-1:0] dm_bc_dt,
  output logic                dm_rd_vld,
  output logic                dm_busy
);

  localparam int DEPTH = 1 << DMA_SIZE;
  localparam int CW    = DMA_SIZE + 1;

  // CLEAR doubles as the busy indication, so dm_busy exposes the FSM state.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       clr_cnt_q, clr_cnt_d;
  logic                clr_last;
  logic                wr_acc, rd_acc;

  logic                mem_we;
  logic [DMA_SIZE-1:0] mem_waddr;
  logic [DMD_SIZE-1:0] mem_wdata;
  logic [DMD_SIZE-1:0] mem_q [DEPTH];

  logic [RD_LAT-1:0]   vld_q, vld_d;
  logic [DMD_SIZE-1:0] dat_q [RD_LAT];
  logic [DMD_SIZE-1:0] dat_d [RD_LAT];
`ifdef DM_WR_FWD_EN
  logic [DMA_SIZE-1:0] adr_q [RD_LAT];
  logic [DMA_SIZE-1:0] adr_d [RD_LAT];
`endif

  assign clr_last = (clr_cnt_q == CW'(DEPTH - 1));

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_CLEAR;
    else       state_q <= state_d;
  end

  // FSM next state: CLEAR runs once through the array, RUN holds until reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (clr_last) state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_CLEAR;
    endcase
  end

  // FSM outputs: busy flag, request qualification, array write port select
  always_comb begin
    dm_busy   = (state_q == ST_CLEAR);
    wr_acc    = ps_dm_cslt &  ps_dm_wrb & ~dm_busy;
    rd_acc    = ps_dm_cslt & ~ps_dm_wrb & ~dm_busy;
    clr_cnt_d = clr_cnt_q;
    mem_we    = 1'b0;
    mem_waddr = dg_dm_add;
    mem_wdata = bc_dt;
    if (dm_busy) begin
      clr_cnt_d = clr_cnt_q + CW'(1);
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q[DMA_SIZE-1:0];
      mem_wdata = '0;
    end else if (wr_acc) begin
      mem_we    = 1'b1;
    end
  end

  // Clear counter; restarts from zero on every reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) clr_cnt_q <= '0;
    else       clr_cnt_q <= clr_cnt_d;
  end

  // Storage array: not reset, zeroed by the clear sequence instead
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Read pipeline next state: stage 0 samples the array, later stages shift
  always_comb begin
    vld_d[0] = rd_acc;
    dat_d[0] = mem_q[dg_dm_add];
`ifdef DM_WR_FWD_EN
    adr_d[0] = dg_dm_add;
`endif
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
`ifdef DM_WR_FWD_EN
      adr_d[i] = adr_q[i-1];
      // A read cannot share an edge with a write, so patching the data as it
      // moves into the next stage covers every in-flight read of the address.
      if (wr_acc && vld_q[i-1] && (adr_q[i-1] == dg_dm_add)) dat_d[i] = bc_dt;
`endif
    end
  end

  // Read pipeline registers; reset kills all in-flight reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        dat_q[i] <= '0;
`ifdef DM_WR_FWD_EN
        adr_q[i] <= '0;
`endif
      end
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
`ifdef DM_WR_FWD_EN
      adr_q <= adr_d;
`endif
    end
  end

  assign dm_rd_vld = vld_q[RD_LAT-1];
  assign dm_bc_dt  = dm_rd_vld ? dat_q[RD_LAT-1] : '0;

endmodule

// File: tb/tb_memory_ext_pipe.sv
// Directed bench for memory_ext_pipe. u_dut2 (RD_LAT = 2) is checked every
// cycle against an expected-data queue; u_dut3 (RD_LAT = 3) shares its inputs
// and is checked for the clear timing and the write-into-read overlap case.
module tb_memory_ext_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0;
  logic        wrb = 1'b0;
  logic [2:0]  add = '0;
  logic [15:0] dt = '0;

  logic [15:0] dat2, dat3;
  logic        vld2, vld3, busy2, busy3;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [15:0] exp_q[$];
  logic [1:0]  exp_v = '0;

`ifdef DM_WR_FWD_EN
  localparam logic [15:0] OVL_EXP = 16'h5555;
`else
  localparam logic [15:0] OVL_EXP = 16'hAAAA;
`endif

  memory_ext_pipe #(.DMA_SIZE(3), .DMD_SIZE(16), .RD_LAT(2)) u_dut2 (
    .clk(clk), .reset(reset), .ps_dm_cslt(cs), .ps_dm_wrb(wrb),
    .dg_dm_add(add), .bc_dt(dt), .dm_bc_dt(dat2), .dm_rd_vld(vld2),
    .dm_busy(busy2)
  );

  memory_ext_pipe #(.DMA_SIZE(3), .DMD_SIZE(16), .RD_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .ps_dm_cslt(cs), .ps_dm_wrb(wrb),
    .dg_dm_add(add), .bc_dt(dt), .dm_bc_dt(dat3), .dm_rd_vld(vld3),
    .dm_busy(busy3)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // per-cycle scoreboard for u_dut2
  task automatic observe();
    check("vld2", vld2, exp_v[1]);
    if (vld2) begin
      check("q_has_entry", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("rd_data2", dat2, exp_q.pop_front());
    end else begin
      check("idle_zero2", dat2, 0);
    end
  endtask

  // kind: 0 idle, 1 write, 2 read; acc says whether a read is expected to be taken
  task automatic step(input int kind, input logic [2:0] a, input logic [15:0] d, input bit acc);
    cs  = (kind != 0);
    wrb = (kind == 1);
    add = a;
    dt  = d;
    if (kind == 2 && acc) exp_q.push_back(d);
    @(posedge clk);
    #1;
    exp_v = {exp_v[0], (kind == 2 && acc)};
    cs  = 1'b0;
    wrb = 1'b0;
    observe();
  endtask

  // 8 clear edges after reset release; optional traffic that must be dropped
  task automatic clear_seq(input bit traffic);
    check("busy_rel2", busy2, 1);
    for (int i = 1; i <= 8; i++) begin
      if (traffic && i == 1)      step(1, 3'd5, 16'h1234, 1'b0);
      else if (traffic && i == 8) step(2, 3'd0, 16'h0000, 1'b0);
      else                        step(0, 3'd0, 16'h0000, 1'b0);
      check("busy_clr2", busy2, (i < 8));
      check("busy_clr3", busy3, (i < 8));
    end
  endtask

  initial begin
    // reset / clear with a dropped write and a dropped read in the last cycle
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy2, 1);
    check("rst_vld", vld2, 0);
    check("rst_dt", dat2, 0);
    reset = 1'b0;
    clear_seq(1'b1);
    step(2, 3'd5, 16'h0000, 1'b1);   // first read after busy falls
    step(2, 3'd0, 16'h0000, 1'b1);
    repeat (3) step(0, 3'd0, 16'h0000, 1'b0);

    // write then read the next cycle
    step(1, 3'd3, 16'hBEEF, 1'b0);
    step(2, 3'd3, 16'hBEEF, 1'b1);
    repeat (3) step(0, 3'd0, 16'h0000, 1'b0);

    // streaming
    for (int i = 0; i < 8; i++) step(1, 3'(i), 16'h0010 + 16'(i), 1'b0);
    for (int i = 7; i >= 0; i--) step(2, 3'(i), 16'h0010 + 16'(i), 1'b1);
    repeat (3) step(0, 3'd0, 16'h0000, 1'b0);

    // write landing on a read still in flight
    step(1, 3'd2, 16'hAAAA, 1'b0);
    step(2, 3'd2, OVL_EXP, 1'b1);
    check("ovl_vld3_a", vld3, 0);
    step(1, 3'd2, 16'h5555, 1'b0);
    check("ovl_vld3_b", vld3, 0);
    step(0, 3'd0, 16'h0000, 1'b0);
    check("ovl_vld3_c", vld3, 1);
    check("ovl_dat3", dat3, OVL_EXP);
    step(0, 3'd0, 16'h0000, 1'b0);
    check("ovl_vld3_d", vld3, 0);
    step(2, 3'd2, 16'h5555, 1'b1);
    repeat (3) step(0, 3'd0, 16'h0000, 1'b0);

    // reset one cycle after a read is accepted
    step(2, 3'd3, 16'h0013, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    check("mid_busy_async", busy2, 1);
    check("mid_vld", vld2, 0);
    check("mid_dt", dat2, 0);
    @(posedge clk);
    #1;
    check("mid_vld_edge", vld2, 0);
    check("mid_vld3_edge", vld3, 0);
    exp_v = '0;
    exp_q.delete();
    reset = 1'b0;
    clear_seq(1'b0);
    step(2, 3'd3, 16'h0000, 1'b1);
    step(2, 3'd7, 16'h0000, 1'b1);
    repeat (3) step(0, 3'd0, 16'h0000, 1'b0);

    check("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
